// File: rtl/conway_stepper_if.sv
// ============================================================================
// Module      : conway_stepper_if
// Description : Control/data bundle between a host and conway_stepper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface conway_stepper_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    logic                   load;
    logic [ROWS*COLS-1:0]   load_data;
    logic                   step;
    logic                   busy;
    logic                   done;
    logic [ROWS*COLS-1:0]   board;
    logic [15:0]            generation;

    modport master (
        output load, load_data, step,
        input  busy, done, board, generation
    );

    modport slave (
        input  load, load_data, step,
        output busy, done, board, generation
    );
endinterface

`default_nettype wire

// File: rtl/conway_stepper.sv
// ============================================================================
// Module      : conway_stepper (with conway_logic)
// Description : Sequential Game of Life engine, one cell per clock through a
//               shared rule block. Macro CONWAY_TORUS_EN selects wrapped edges.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conway_logic (
    input  wire logic [7:0] in,
    input  wire logic       prev_state,
    output logic            next_state
);
    logic [3:0] w_count;

    always_comb begin
        w_count = '0;
        for (int i = 0; i < 8; i++) begin
            w_count = w_count + {3'b000, in[i]};
        end
    end

    assign next_state = (w_count == 4'd3) | (prev_state & (w_count == 4'd2));
endmodule

module conway_stepper #(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    conway_stepper_if.slave  bus
);
    localparam int N  = ROWS * COLS;
    localparam int IW = $clog2(N);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    localparam logic [IW-1:0] C_LAST_IDX = IW'(N - 1);
    localparam logic [RW-1:0] C_LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] C_LAST_COL = CW'(COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_board;
    logic [N-1:0]    r_shadow;
    logic [IW-1:0]   r_idx;
    logic [RW-1:0]   r_row;
    logic [CW-1:0]   r_col;
    logic [15:0]     r_gen;
    logic            r_done;

    logic [RW-1:0]   w_rn, w_rs;
    logic [CW-1:0]   w_cw, w_ce;
    logic            w_vn, w_vs, w_vw, w_ve;
    logic [IW-1:0]   w_bn, w_bc, w_bs;
    logic [7:0]      w_nbr;
    logic            w_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (!bus.load && bus.step) w_state_nxt = S_SCAN;
            S_SCAN:   if (r_idx == C_LAST_IDX)   w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Neighbour coordinates always wrap so every index stays in range; the
    // validity flags decide whether an off-board neighbour counts.
    assign w_rn = (r_row == '0)         ? C_LAST_ROW : r_row - 1'b1;
    assign w_rs = (r_row == C_LAST_ROW) ? '0         : r_row + 1'b1;
    assign w_cw = (r_col == '0)         ? C_LAST_COL : r_col - 1'b1;
    assign w_ce = (r_col == C_LAST_COL) ? '0         : r_col + 1'b1;

`ifdef CONWAY_TORUS_EN
    assign w_vn = 1'b1;
    assign w_vs = 1'b1;
    assign w_vw = 1'b1;
    assign w_ve = 1'b1;
`else
    assign w_vn = (r_row != '0);
    assign w_vs = (r_row != C_LAST_ROW);
    assign w_vw = (r_col != '0);
    assign w_ve = (r_col != C_LAST_COL);
`endif

    assign w_bn = IW'(w_rn  * COLS);
    assign w_bc = IW'(r_row * COLS);
    assign w_bs = IW'(w_rs  * COLS);

    assign w_nbr = {
        w_vn & w_vw & r_board[w_bn + IW'(w_cw)],
        w_vn        & r_board[w_bn + IW'(r_col)],
        w_vn & w_ve & r_board[w_bn + IW'(w_ce)],
        w_vw        & r_board[w_bc + IW'(w_cw)],
        w_ve        & r_board[w_bc + IW'(w_ce)],
        w_vs & w_vw & r_board[w_bs + IW'(w_cw)],
        w_vs        & r_board[w_bs + IW'(r_col)],
        w_vs & w_ve & r_board[w_bs + IW'(w_ce)]
    };

    conway_logic u_logic (
        .in         (w_nbr),
        .prev_state (r_board[r_idx]),
        .next_state (w_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_board  <= '0;
            r_shadow <= '0;
            r_idx    <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_gen    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.load) begin
                        r_board <= bus.load_data;
                        r_gen   <= '0;
                    end else if (bus.step) begin
                        r_idx <= '0;
                        r_row <= '0;
                        r_col <= '0;
                    end
                end
                S_SCAN: begin
                    r_shadow[r_idx] <= w_next;
                    if (r_idx != C_LAST_IDX) begin
                        r_idx <= r_idx + 1'b1;
                        if (r_col == C_LAST_COL) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    r_board <= r_shadow;
                    r_gen   <= r_gen + 16'd1;
                    r_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = r_done;
    assign bus.board      = r_board;
    assign bus.generation = r_gen;
endmodule

`default_nettype wire

// File: doc/conway_stepper.md
# conway_stepper

Sequential generation engine for the Game of Life datapath. It holds a ROWS×COLS board in registers and, on each accepted step request, scans the board one cell per clock. For each cell it gathers the eight neighbours into a single shared `conway_logic` instance and writes the result into a shadow board. At the end of the scan it commits the shadow board and advances a generation counter. This is the stage directly upstream of `conway_logic`: it produces that block's `in[7:0]`/`prev_state` and consumes its `next_state`.

## Interface
- `ROWS`, 8, board height (≥3)
- `COLS`, 8, board width (≥3)
- `clk`  input  1  sole clock; all state updates on rising edge
- `rst`  input  1  synchronous, active-high reset
- `load`  input  1  in IDLE: copy `load_data` into board
- `load_data`  input  ROWS*COLS  initial board; bit r*COLS+c = cell (r,c)
- `step`  input  1  in IDLE: start one generation
- `busy`  output  1  high while in SCAN or COMMIT
- `done`  output  1  one-cycle pulse after the board commits
- `board`  output  ROWS*COLS  current generation, same bit mapping as `load_data`
- `generation`  output  16  count of committed generations

## Operation
- States: IDLE, SCAN, COMMIT. Reset state is IDLE.
- IDLE:
  - `load`=1: board←`load_data`, generation←0, stay IDLE.
  - Else `step`=1: idx←0, go to SCAN.
  - `load` has priority over `step` when both are high.
- SCAN: each cycle, cell idx (r=idx/COLS, c=idx%COLS) drives `conway_logic`.
  - prev_state = board[idx].
  - in[7:0] = {NW, N, NE, W, E, SW, S, SE} relative to (r,c). N is row r−1. W is column c−1.
  - shadow[idx] ← next_state.
  - At idx = ROWS*COLS−1, go to COMMIT. Otherwise idx++.
- COMMIT: board←shadow, generation←generation+1, `done`←1, go to IDLE.
- The live board is never modified during SCAN. All neighbour reads see generation g only.
- `step` and `load` are ignored (not queued) while `busy`=1.
- generation is 16-bit and wraps 0xFFFF→0x0000.
- Out-of-range neighbours are governed by the macro under Configuration.

## Timing
- Reset values: board=0, generation=0, busy=0, done=0, state IDLE, idx=0, shadow=0.
- `step` accepted at edge k:
  - busy=1 from edge k.
  - Cells 0..N−1 are evaluated in cycles k..k+N−1, where N=ROWS*COLS.
  - COMMIT occurs in cycle k+N. At edge k+N+1, board and generation update, done=1 and busy=0.
  - Total: N+1 cycles from acceptance to new board (65 for 8×8).
- `done` is high exactly one cycle. A new `step` may be accepted in that same cycle.
- `load` takes effect at the sampling edge and is visible on `board` the next cycle. It does not pulse `done`.
- `rst` mid-SCAN or mid-COMMIT: the next cycle shows the reset values. The partial shadow is discarded and no commit occurs.

## Configuration
- `CONWAY_TORUS_EN` defined: edges wrap. Row −1 maps to ROWS−1, row ROWS to 0, and columns likewise.
- Undefined: any neighbour outside the board reads as dead (0).
- All other behaviour is identical with or without the macro.

## Test plan
- **Blinker (8×8).** Load bits 26, 27, 28 (row 3, cols 2–4), then pulse `step`. Required:
  - busy high for 65 cycles, then a single done pulse.
  - board = bits 19, 27, 35 only; generation=1.
  - A second step restores bits 26, 27, 28; generation=2.
- **Block still life.** Load bits 9, 10, 17, 18. After 3 steps, board is unchanged and generation=3.
- **Corner wrap.** Load bits 7, 56, 63, then step.
  - With `CONWAY_TORUS_EN`: board = bits 0, 7, 56, 63.
  - Without it: board = 0.
- **Ignored requests.** Pulse `step`, then pulse `load` (data all 1s) and `step` at scan cycle 10. Required:
  - Load and the second step are dropped.
  - Exactly one done pulse; board = blinker result; generation=1.
- **Reset mid-scan.** Start a blinker step and assert `rst` at scan cycle 20 for one cycle. Next cycle: board=0, generation=0, busy=0, done=0, and no done pulse follows.
- **Load/step priority.** Assert `load` and `step` together in IDLE. The board is loaded, busy stays 0 and generation=0.
